// File: rtl/fx68k_bus_sched_if.sv
// Bus-scheduler signal bundle: phase enables, core/DMA requests, pad-side strobes, per-requester completion.
// The slave modport is the scheduler side; the master modport is the core/DMA/pad side.
interface fx68k_bus_sched_if;
  logic enPhi1;
  logic enPhi2;
  logic coreReq;
  logic coreWrite;
  logic coreNoLow;
  logic coreNoHigh;
  logic dmaReq;
  logic dmaWrite;
  logic dmaNoLow;
  logic dmaNoHigh;
  logic DTACKn;
  logic BERRn;
  logic ASn;
  logic UDSn;
  logic LDSn;
  logic RWn;
  logic busOwner;
  logic busy;
  logic dataLatch;
  logic coreDone;
  logic dmaDone;
  logic busErr;

  modport slave (
    input  enPhi1, enPhi2,
    input  coreReq, coreWrite, coreNoLow, coreNoHigh,
    input  dmaReq, dmaWrite, dmaNoLow, dmaNoHigh,
    input  DTACKn, BERRn,
    output ASn, UDSn, LDSn, RWn,
    output busOwner, busy, dataLatch, coreDone, dmaDone, busErr
  );

  modport master (
    output enPhi1, enPhi2,
    output coreReq, coreWrite, coreNoLow, coreNoHigh,
    output dmaReq, dmaWrite, dmaNoLow, dmaNoHigh,
    output DTACKn, BERRn,
    input  ASn, UDSn, LDSn, RWn,
    input  busOwner, busy, dataLatch, coreDone, dmaDone, busErr
  );
endinterface

// File: rtl/fx68k_bus_sched.sv
// 68000 bus-cycle FSM with core/DMA arbitration; zero-wait cycle is 6 phase ticks from grant, DTACKn stretches WAIT.
// Requests are held levels acknowledged by done pulses; FX68K_BUS_TIMEOUT_EN adds a self-generated bus error after TIMEOUT waits.
module fx68k_bus_sched #(
  parameter int CORE_BURST = 4,
  parameter int TIMEOUT    = 31
) (
  input logic               clk,
  input logic               nRst,
  fx68k_bus_sched_if.slave  bus
);

  if (CORE_BURST < 1 || CORE_BURST > 15) begin : g_bad_burst
    $error("CORE_BURST must be 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_STROBE,
    S_WAIT,
    S_DATA,
    S_TERM
  } state_t;

  state_t     r_state;
  logic       r_write;
  logic       r_no_low;
  logic       r_no_high;
  logic       r_err;
  logic [3:0] r_streak;

  logic       w_core_win;
  logic       w_sel_write;
  logic       w_sel_no_low;
  logic       w_sel_no_high;
  logic [3:0] w_streak_inc;

  // Core keeps the bus until it has used up its burst allowance against a waiting DMA.
  assign w_core_win    = bus.coreReq && (!bus.dmaReq || (r_streak < 4'(CORE_BURST)));
  assign w_sel_write   = w_core_win ? bus.coreWrite  : bus.dmaWrite;
  assign w_sel_no_low  = w_core_win ? bus.coreNoLow  : bus.dmaNoLow;
  assign w_sel_no_high = w_core_win ? bus.coreNoHigh : bus.dmaNoHigh;
  assign w_streak_inc  = (r_streak == 4'd15) ? 4'd15 : r_streak + 4'd1;

`ifdef FX68K_BUS_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_nxt;
  assign w_wait_nxt = r_wait_cnt + 8'd1;
`endif

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state       <= S_IDLE;
      r_write       <= 1'b0;
      r_no_low      <= 1'b0;
      r_no_high     <= 1'b0;
      r_err         <= 1'b0;
      r_streak      <= 4'd0;
`ifdef FX68K_BUS_TIMEOUT_EN
      r_wait_cnt    <= 8'd0;
`endif
      bus.ASn       <= 1'b1;
      bus.UDSn      <= 1'b1;
      bus.LDSn      <= 1'b1;
      bus.RWn       <= 1'b1;
      bus.busOwner  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.dataLatch <= 1'b0;
      bus.coreDone  <= 1'b0;
      bus.dmaDone   <= 1'b0;
      bus.busErr    <= 1'b0;
    end else begin
      bus.dataLatch <= 1'b0;
      bus.coreDone  <= 1'b0;
      bus.dmaDone   <= 1'b0;
      bus.busErr    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.enPhi1 && (bus.coreReq || bus.dmaReq)) begin
            bus.busOwner <= !w_core_win;
            bus.busy     <= 1'b1;
            r_write      <= w_sel_write;
            r_no_low     <= w_sel_no_low;
            r_no_high    <= w_sel_no_high;
            r_err        <= 1'b0;
`ifdef FX68K_BUS_TIMEOUT_EN
            r_wait_cnt   <= 8'd0;
`endif
            if (w_core_win && bus.dmaReq) r_streak <= w_streak_inc;
            else                          r_streak <= 4'd0;
            // With both lanes suppressed there is nothing to strobe; finish on the next PHI2.
            r_state <= (w_sel_no_low && w_sel_no_high) ? S_TERM : S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus.enPhi2) begin
            bus.ASn <= 1'b0;
            bus.RWn <= !r_write;
            if (!r_write) begin
              bus.UDSn <= r_no_high;
              bus.LDSn <= r_no_low;
            end
            r_state <= S_STROBE;
          end
        end
        S_STROBE: begin
          if (bus.enPhi1) begin
            if (r_write) begin
              bus.UDSn <= r_no_high;
              bus.LDSn <= r_no_low;
            end
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.enPhi2) begin
            if (!bus.DTACKn) begin
              r_state <= S_DATA;
            end else if (!bus.BERRn) begin
              r_err   <= 1'b1;
              r_state <= S_TERM;
            end else begin
`ifdef FX68K_BUS_TIMEOUT_EN
              r_wait_cnt <= w_wait_nxt;
              if (w_wait_nxt == 8'(TIMEOUT)) begin
                r_err   <= 1'b1;
                r_state <= S_TERM;
              end
`endif
            end
          end
        end
        S_DATA: begin
          if (bus.enPhi1) begin
            bus.dataLatch <= 1'b1;
            r_state       <= S_TERM;
          end
        end
        S_TERM: begin
          if (bus.enPhi2) begin
            bus.ASn      <= 1'b1;
            bus.UDSn     <= 1'b1;
            bus.LDSn     <= 1'b1;
            bus.RWn      <= 1'b1;
            bus.busy     <= 1'b0;
            bus.coreDone <= !bus.busOwner;
            bus.dmaDone  <= bus.busOwner;
            bus.busErr   <= r_err;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx68k_bus_sched.sv
// Scoreboard bench for fx68k_bus_sched: directed cycles push expected completions, a monitor checks each done pulse.
// Phase enables alternate every clk (PHI1, PHI2, ...); a responder drives DTACKn/BERRn per configured wait/error tick.
module tb_fx68k_bus_sched;

  logic clk = 1'b0;
  logic nRst;

  fx68k_bus_sched_if bus ();

  fx68k_bus_sched #(.CORE_BURST(4), .TIMEOUT(31)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit dma;
    bit err;
    int dl;
    int len;
    bit as_low;
    bit uds_low;
    bit lds_low;
    bit rw_low;
    int ds_dly;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int dtack_waits = 0;
  int berr_at = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit dma, input bit err, input int dl, input int len,
                              input bit as_l, input bit uds, input bit lds, input bit rw,
                              input int dly);
    exp_t e;
    e.dma = dma; e.err = err; e.dl = dl; e.len = len;
    e.as_low = as_l; e.uds_low = uds; e.lds_low = lds; e.rw_low = rw; e.ds_dly = dly;
    return e;
  endfunction

  // Alternating phase enables: the edge after a negedge where enPhi1=1 is a PHI1 edge.
  initial begin
    bus.enPhi1 = 1'b1;
    bus.enPhi2 = 1'b0;
    forever begin
      @(negedge clk);
      bus.enPhi1 = ~bus.enPhi1;
      bus.enPhi2 = ~bus.enPhi2;
    end
  end

  // Slave responder: counts PHI2 edges while ASn is low and answers on the configured sample.
  initial begin
    int idx;
    idx = 0;
    bus.DTACKn = 1'b1;
    bus.BERRn  = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (!nRst || bus.ASn) begin
        idx = 0;
        bus.DTACKn = 1'b1;
        bus.BERRn  = 1'b1;
      end else if (bus.enPhi2) begin
        idx++;
        bus.DTACKn = (idx > dtack_waits) ? 1'b0 : 1'b1;
        bus.BERRn  = (berr_at != 0 && idx >= berr_at) ? 1'b0 : 1'b1;
      end
    end
  end

  // Monitor: accumulates per-cycle observations, compares against the scoreboard on each done pulse.
  initial begin
    int busy_cnt, dl_cnt, as_at, ds_at;
    bit own0, own1, uds_l, lds_l, rw_l;
    exp_t e;
    busy_cnt = 0; dl_cnt = 0; as_at = -1; ds_at = -1;
    own0 = 0; own1 = 0; uds_l = 0; lds_l = 0; rw_l = 0;
    forever begin
      @(negedge clk);
      if (!nRst) begin
        busy_cnt = 0; dl_cnt = 0; as_at = -1; ds_at = -1;
        own0 = 0; own1 = 0; uds_l = 0; lds_l = 0; rw_l = 0;
      end else begin
        if (bus.busy) begin
          busy_cnt++;
          if (!bus.ASn && as_at < 0) as_at = busy_cnt;
          if ((!bus.UDSn || !bus.LDSn) && ds_at < 0) ds_at = busy_cnt;
          if (!bus.UDSn) uds_l = 1;
          if (!bus.LDSn) lds_l = 1;
          if (!bus.RWn) rw_l = 1;
          if (bus.busOwner) own1 = 1; else own0 = 1;
        end
        if (bus.dataLatch) dl_cnt++;
        if (bus.coreDone || bus.dmaDone) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got core=%0b dma=%0b expected no completion", bus.coreDone, bus.dmaDone);
          end else begin
            e = sb.pop_front();
            chk("done_select", {bus.coreDone, bus.dmaDone}, e.dma ? 2'b01 : 2'b10);
            chk("bus_owner", {own0, own1}, e.dma ? 2'b01 : 2'b10);
            chk("bus_err", bus.busErr, e.err);
            chk("data_latch_pulses", dl_cnt, e.dl);
            chk("cycle_ticks", busy_cnt + 1, e.len);
            chk("strobe_lanes", {as_at >= 0, uds_l, lds_l, rw_l},
                {e.as_low, e.uds_low, e.lds_low, e.rw_low});
            chk("ds_after_as", (ds_at < 0) ? -1 : ds_at - as_at, e.ds_dly);
            chk("strobes_released", {bus.ASn, bus.UDSn, bus.LDSn, bus.RWn}, 4'hF);
          end
          busy_cnt = 0; dl_cnt = 0; as_at = -1; ds_at = -1;
          own0 = 0; own1 = 0; uds_l = 0; lds_l = 0; rw_l = 0;
        end
      end
    end
  end

  task automatic wait_done(input bit dma, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = dma ? bus.dmaDone : bus.coreDone;
    end
    chk(dma ? "dma_done_arrived" : "core_done_arrived", seen, 1);
    #1;
  endtask

  task automatic core_cycle(input bit wr, input bit nl, input bit nh, input exp_t e);
    sb.push_back(e);
    bus.coreWrite  = wr;
    bus.coreNoLow  = nl;
    bus.coreNoHigh = nh;
    bus.coreReq    = 1'b1;
    wait_done(1'b0, 400);
    bus.coreReq = 1'b0;
  endtask

  task automatic dma_cycle(input bit wr, input bit nl, input bit nh, input exp_t e);
    sb.push_back(e);
    bus.dmaWrite  = wr;
    bus.dmaNoLow  = nl;
    bus.dmaNoHigh = nh;
    bus.dmaReq    = 1'b1;
    wait_done(1'b1, 400);
    bus.dmaReq = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected $finish before 200us");
    $fatal(1);
  end

  initial begin
    int n;
    nRst = 1'b1;
    bus.coreReq = 0; bus.coreWrite = 0; bus.coreNoLow = 0; bus.coreNoHigh = 0;
    bus.dmaReq  = 0; bus.dmaWrite  = 0; bus.dmaNoLow  = 0; bus.dmaNoHigh  = 0;
    #2 nRst = 1'b0;
    #2;
    chk("rst_strobes", {bus.ASn, bus.UDSn, bus.LDSn, bus.RWn}, 4'hF);
    chk("rst_busy_owner", {bus.busy, bus.busOwner}, 2'b00);
    chk("rst_pulses", {bus.dataLatch, bus.coreDone, bus.dmaDone, bus.busErr}, 4'h0);
    repeat (3) @(negedge clk);
    #1 nRst = 1'b1;

    // Zero-wait core word read.
    core_cycle(1'b0, 1'b0, 1'b0, mk(0, 0, 1, 6, 1, 1, 1, 0, 0));
    // DMA low-byte write with three wait states.
    dtack_waits = 3;
    dma_cycle(1'b1, 1'b0, 1'b1, mk(1, 0, 1, 12, 1, 0, 1, 1, 1));
    dtack_waits = 0;
    // Both lanes suppressed: no bus activity, quick clean completion.
    core_cycle(1'b1, 1'b1, 1'b1, mk(0, 0, 0, 2, 0, 0, 0, 0, -1));
    // DTACKn and BERRn together: normal completion.
    berr_at = 1;
    core_cycle(1'b0, 1'b0, 1'b0, mk(0, 0, 1, 6, 1, 1, 1, 0, 0));
    // BERRn on the second WAIT sample of a DMA read.
    dtack_waits = 1000;
    berr_at = 2;
    dma_cycle(1'b0, 1'b0, 1'b0, mk(1, 1, 0, 8, 1, 1, 1, 0, 0));
    dtack_waits = 0;
    berr_at = 0;

    // Continuous contention: core x4, DMA x1, repeated.
    for (int k = 0; k < 10; k++)
      sb.push_back(mk((k % 5) == 4, 0, 1, 6, 1, 1, 1, 0, 0));
    bus.coreWrite = 0; bus.coreNoLow = 0; bus.coreNoHigh = 0;
    bus.dmaWrite  = 0; bus.dmaNoLow  = 0; bus.dmaNoHigh  = 0;
    bus.coreReq = 1'b1;
    bus.dmaReq  = 1'b1;
    n = 0;
    for (int i = 0; i < 2000 && n < 10; i++) begin
      @(negedge clk);
      if (bus.coreDone || bus.dmaDone) n++;
    end
    #1;
    bus.coreReq = 1'b0;
    bus.dmaReq  = 1'b0;
    chk("burst_done_count", n, 10);

    // No DTACKn/BERRn for a long time.
`ifdef FX68K_BUS_TIMEOUT_EN
    dtack_waits = 1000;
    core_cycle(1'b0, 1'b0, 1'b0, mk(0, 1, 0, 66, 1, 1, 1, 0, 0));
`else
    dtack_waits = 110;
    core_cycle(1'b0, 1'b0, 1'b0, mk(0, 0, 1, 226, 1, 1, 1, 0, 0));
`endif

    // Reset in the middle of a stalled core write, with DMA pending.
    dtack_waits = 1000;
    bus.coreWrite = 1; bus.coreNoLow = 0; bus.coreNoHigh = 0;
    bus.coreReq = 1'b1;
    for (int i = 0; i < 20 && !(bus.busy && !bus.LDSn); i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("pre_rst_strobes", {bus.ASn, bus.UDSn, bus.LDSn, bus.RWn}, 4'h0);
    bus.dmaWrite = 0; bus.dmaNoLow = 0; bus.dmaNoHigh = 0;
    bus.dmaReq = 1'b1;
    #1;
    bus.coreReq = 1'b0;
    nRst = 1'b0;
    #1;
    chk("mid_rst_strobes", {bus.ASn, bus.UDSn, bus.LDSn, bus.RWn}, 4'hF);
    chk("mid_rst_busy", bus.busy, 0);
    dtack_waits = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (bus.enPhi1) break;
    end
    sb.push_back(mk(1, 0, 1, 6, 1, 1, 1, 0, 0));
    nRst = 1'b1;
    @(negedge clk);
    chk("grant_after_rst", {bus.busy, bus.busOwner}, 2'b11);
    wait_done(1'b1, 400);
    bus.dmaReq = 1'b0;

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fx68k_bus_sched.md
Name: fx68k_bus_sched

Overview:
- Schedules 68000-style asynchronous bus cycles and arbitrates the external bus between two requesters: the CPU core (nanocode-issued accesses) and an external DMA master.
- Runs a phase-accurate bus-cycle FSM clocked by the enPhi1/enPhi2 enables.
- Drives ASn/UDSn/LDSn/RWn and returns done/error per requester.
- Sits between the core's nanocode bus-control fields and the pad ring.

Parameters:
- CORE_BURST, 4: max consecutive core cycles granted while dmaReq is pending; 1..15.
- TIMEOUT, 31: enPhi2 wait ticks without DTACKn/BERRn before a self-generated bus error; 1..255.

Ports:
- clk  in  1  system clock.
- nRst  in  1  asynchronous active-low reset.
- enPhi1  in  1  clock enable; next clk edge is PHI1.
- enPhi2  in  1  clock enable; next clk edge is PHI2.
- coreReq  in  1  core cycle request (level); held until coreDone.
- coreWrite  in  1  1 = write.
- coreNoLow  in  1  suppress LDSn.
- coreNoHigh  in  1  suppress UDSn.
- dmaReq  in  1  DMA cycle request (level); held until dmaDone.
- dmaWrite  in  1  1 = write.
- dmaNoLow  in  1  suppress LDSn.
- dmaNoHigh  in  1  suppress UDSn.
- DTACKn  in  1  data acknowledge (pre-synchronised).
- BERRn  in  1  bus error (pre-synchronised).
- ASn  out  1  address strobe.
- UDSn  out  1  upper data strobe.
- LDSn  out  1  lower data strobe.
- RWn  out  1  1 = read.
- busOwner  out  1  0 = core, 1 = DMA; valid while not IDLE.
- busy  out  1  FSM not IDLE.
- dataLatch  out  1  one-clk pulse: read data valid / write data may be released.
- coreDone  out  1  one-clk pulse ending a core cycle.
- dmaDone  out  1  one-clk pulse ending a DMA cycle.
- busErr  out  1  qualifies the done pulse; 1 = cycle ended in error.

Behaviour:
- Reset (async, nRst=0): state IDLE; ASn=UDSn=LDSn=RWn=1; busOwner=0; busy, dataLatch, coreDone, dmaDone, busErr=0; streak and wait counters=0. Reset mid-cycle drops all strobes in the same clk.
- States (each advances only on the stated enable):
  - IDLE: on enPhi1 with any request, arbitrate. Latch owner, write and lane bits; clear the wait counter; go to ADDR.
  - ADDR: on enPhi2, ASn=0 and RWn=!write. For a read, assert the enabled DS lanes now. Go to STROBE.
  - STROBE: on enPhi1, for a write assert the enabled DS lanes. Go to WAIT.
  - WAIT: on enPhi2, evaluated in priority order:
    - DTACKn=0: go to DATA.
    - else BERRn=0: go to TERM with error.
    - else increment the wait counter; reaching TIMEOUT goes to TERM with error.
  - DATA: on enPhi1, pulse dataLatch for 1 clk; go to TERM.
  - TERM: on enPhi2, ASn/UDSn/LDSn=1, RWn=1. Pulse the owner's done for 1 clk with busErr; go to IDLE.
- Arbitration in IDLE:
  - Only one requester active: grant it.
  - Both active: core wins unless streak>=CORE_BURST, in which case DMA wins.
  - Streak counter: +1 per granted core cycle (saturating), cleared whenever a DMA cycle is granted or dmaReq=0 at arbitration.
- Both lane-suppress bits set: the cycle is granted but runs no bus activity (strobes stay high). The owner's done pulses on the next enPhi2 with busErr=0; the FSM returns to IDLE.
- A done pulse coincident with the same requester still asserting req: the request is treated as new at the next enPhi1 in IDLE. Minimum gap between cycles is 1 PHI1.
- DTACKn and BERRn both low in WAIT: DTACKn wins (normal completion).
- Inputs other than req are sampled only at arbitration. Changes during a cycle are ignored.
- enPhi1 and enPhi2 never assert together; behaviour in that case is undefined.

Optional Feature:
- FX68K_BUS_TIMEOUT_EN defined: the TIMEOUT counter is active as described.
- Undefined: no wait counter is implemented. WAIT holds indefinitely until DTACKn or BERRn; busErr arises only from BERRn.

Test Plan:
- Core read, coreNoLow=0, coreNoHigh=0, DTACKn=0 at first WAIT sample:
  - ASn/UDSn/LDSn fall at ADDR; dataLatch 1 PHI1 later; coreDone=1 with busErr=0.
  - Cycle is 6 enable ticks from grant; RWn stays 1.
- DMA byte write, dmaNoHigh=1, DTACKn delayed 3 PHI2s:
  - LDSn falls one phase after ASn; UDSn stays 1; RWn=0.
  - 3 wait ticks inserted; dmaDone=1, busOwner=1.
- Both requesters continuously active with CORE_BURST=4: grant sequence is core×4, DMA×1, core×4, DMA×1.
- FX68K_BUS_TIMEOUT_EN defined, TIMEOUT=31, DTACKn=BERRn=1:
  - TERM reached after the 31st wait tick; coreDone with busErr=1; strobes deasserted.
  - Repeat with the macro undefined: busy stays 1 for >100 PHI2s until DTACKn=0.
- BERRn=0 at the second WAIT sample of a DMA read: dmaDone with busErr=1; dataLatch never pulses.
- nRst low during WAIT of a core write: ASn/UDSn/LDSn/RWn=1 within the same clk. After release, a pending dmaReq is granted on the next enPhi1.
